// File: rtl/lbm_sweep_ctrl.sv
// Raster-order sweep sequencer for one lattice-Boltzmann streaming pass.
// Issues each cell's (hor, vert) on all 9 neighbour lanes and emits a delayed write-back coordinate.
module lbm_sweep_ctrl #(
  parameter int HPIXELS      = 205,
  parameter int VPIXELS      = 154,
  parameter int LATENCY      = 3,
  parameter int READ_LATENCY = 2,
  localparam int HOR_SIZE    = $clog2(HPIXELS),
  localparam int VERT_SIZE   = $clog2(VPIXELS),
  localparam int D           = LATENCY + READ_LATENCY
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            start_in,
  input  logic                            stall_in,
  output logic [8:0][HOR_SIZE-1:0]        hor_out,
  output logic [8:0][VERT_SIZE-1:0]       vert_out,
  output logic                            valid_out,
  output logic                            wb_valid_out,
  output logic [HOR_SIZE-1:0]             wb_hor_out,
  output logic [VERT_SIZE-1:0]            wb_vert_out,
  output logic                            busy_out,
  output logic                            done_out,
  output logic [15:0]                     frame_count_out
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int DW = $clog2(D + 1);
  localparam logic [HOR_SIZE-1:0]  COL_LAST   = HOR_SIZE'(HPIXELS - 1);
  localparam logic [VERT_SIZE-1:0] ROW_LAST   = VERT_SIZE'(VPIXELS - 1);
  localparam logic [DW-1:0]        DRAIN_LAST = DW'(D);

  logic [1:0]           state_q, state_d;
  logic [HOR_SIZE-1:0]  col_q, col_d;
  logic [VERT_SIZE-1:0] row_q, row_d;
  logic [DW-1:0]        drain_q, drain_d;
  logic                 vld_q, vld_d;
  logic [HOR_SIZE-1:0]  hor_q, hor_d;
  logic [VERT_SIZE-1:0] vert_q, vert_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [15:0]          frame_count_q, frame_count_d;

  logic                 issue;
  logic [HOR_SIZE-1:0]  cur_col;
  logic [VERT_SIZE-1:0] cur_row;

  logic                 dly_vld_q  [D];
  logic                 dly_vld_d  [D];
  logic [HOR_SIZE-1:0]  dly_hor_q  [D];
  logic [HOR_SIZE-1:0]  dly_hor_d  [D];
  logic [VERT_SIZE-1:0] dly_vert_q [D];
  logic [VERT_SIZE-1:0] dly_vert_d [D];

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    drain_d       = drain_q;
    vld_d         = 1'b0;
    hor_d         = hor_q;
    vert_d        = vert_q;
    done_d        = 1'b0;
    frame_count_d = frame_count_q;
    issue         = 1'b0;
    cur_col       = col_q;
    cur_row       = row_q;

    case (state_q)
      ST_IDLE: begin
        // The start edge itself issues cell (0,0) so the first cell appears one cycle later.
        if (start_in) begin
          issue   = 1'b1;
          cur_col = '0;
          cur_row = '0;
          state_d = ST_SWEEP;
        end
      end
      ST_SWEEP: issue = !stall_in;
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d       = ST_IDLE;
        frame_count_d = frame_count_q + 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (issue) begin
      vld_d  = 1'b1;
      hor_d  = cur_col;
      vert_d = cur_row;
      if (cur_col == COL_LAST) begin
        col_d = '0;
        if (cur_row == ROW_LAST) begin
          row_d   = '0;
          drain_d = '0;
          state_d = ST_DRAIN;
        end else begin
          row_d = cur_row + 1'b1;
        end
      end else begin
        col_d = cur_col + 1'b1;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Write-back delay line: shifts every cycle, independent of stall.
  always_comb begin
    dly_vld_d[0]  = vld_q;
    dly_hor_d[0]  = hor_q;
    dly_vert_d[0] = vert_q;
    for (int i = 1; i < D; i++) begin
      dly_vld_d[i]  = dly_vld_q[i-1];
      dly_hor_d[i]  = dly_hor_q[i-1];
      dly_vert_d[i] = dly_vert_q[i-1];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= ST_IDLE;
      col_q         <= '0;
      row_q         <= '0;
      drain_q       <= '0;
      vld_q         <= 1'b0;
      hor_q         <= '0;
      vert_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      frame_count_q <= '0;
      for (int i = 0; i < D; i++) begin
        dly_vld_q[i]  <= 1'b0;
        dly_hor_q[i]  <= '0;
        dly_vert_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      drain_q       <= drain_d;
      vld_q         <= vld_d;
      hor_q         <= hor_d;
      vert_q        <= vert_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      frame_count_q <= frame_count_d;
      for (int i = 0; i < D; i++) begin
        dly_vld_q[i]  <= dly_vld_d[i];
        dly_hor_q[i]  <= dly_hor_d[i];
        dly_vert_q[i] <= dly_vert_d[i];
      end
    end
  end

  assign hor_out         = {9{hor_q}};
  assign vert_out        = {9{vert_q}};
  assign valid_out       = vld_q;
  assign wb_valid_out    = dly_vld_q[D-1];
  assign wb_hor_out      = dly_hor_q[D-1];
  assign wb_vert_out     = dly_vert_q[D-1];
  assign busy_out        = busy_q;
  assign done_out        = done_q;
  assign frame_count_out = frame_count_q;

endmodule

// File: tb/tb_lbm_sweep_ctrl.sv
// Scoreboard bench for lbm_sweep_ctrl: randomized stall/start stimulus against a cell-schedule model,
// plus a full-size instance for the frame counter wrap.
module tb_lbm_sweep_ctrl;

  localparam int HP = 4;
  localparam int VP = 3;
  localparam int D  = 5;
  localparam int N  = HP * VP;

  typedef struct {
    int h;
    int v;
    int c;
  } ev_t;

  logic clk = 1'b0;
  logic rst_in, start_in, stall_in;
  logic [8:0][1:0] hor_out;
  logic [8:0][1:0] vert_out;
  logic valid_out, wb_valid_out, busy_out, done_out;
  logic [1:0] wb_hor_out, wb_vert_out;
  logic [15:0] frame_count_out;

  logic start2, stall2;
  logic [8:0][7:0] hor2;
  logic [8:0][7:0] vert2;
  logic valid2, wb_valid2, busy2, done2;
  logic [7:0] wb_hor2, wb_vert2;
  logic [15:0] fc2;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  ev_t iss_q[$];
  ev_t wb_q[$];
  int done_q[$];
  int exp_fc = 0;
  int busy_lo = 1, busy_hi = 0;
  int hold_h = 0, hold_v = 0;
  ev_t me;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lbm_sweep_ctrl #(.HPIXELS(HP), .VPIXELS(VP), .LATENCY(3), .READ_LATENCY(2)) dut (
    .clk_in(clk), .rst_in(rst_in), .start_in(start_in), .stall_in(stall_in),
    .hor_out(hor_out), .vert_out(vert_out), .valid_out(valid_out),
    .wb_valid_out(wb_valid_out), .wb_hor_out(wb_hor_out), .wb_vert_out(wb_vert_out),
    .busy_out(busy_out), .done_out(done_out), .frame_count_out(frame_count_out)
  );

  lbm_sweep_ctrl dut2 (
    .clk_in(clk), .rst_in(rst_in), .start_in(start2), .stall_in(stall2),
    .hor_out(hor2), .vert_out(vert2), .valid_out(valid2),
    .wb_valid_out(wb_valid2), .wb_hor_out(wb_hor2), .wb_vert_out(wb_vert2),
    .busy_out(busy2), .done_out(done2), .frame_count_out(fc2)
  );

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Monitor: every output the DUT presents is checked against the scoreboard.
  always @(negedge clk) begin
    if (mon_en && !rst_in) begin
      if (valid_out) begin
        if (iss_q.size() == 0) begin
          chk("unexpected_issue", 1, 0);
        end else begin
          me = iss_q.pop_front();
          chk("issue_cycle", cyc, me.c);
          for (int l = 0; l < 9; l++) begin
            chk("issue_hor", int'(hor_out[l]), me.h);
            chk("issue_vert", int'(vert_out[l]), me.v);
          end
          hold_h = me.h;
          hold_v = me.v;
          wb_q.push_back('{me.h, me.v, cyc + D});
        end
      end else begin
        for (int l = 0; l < 9; l++) begin
          chk("hold_hor", int'(hor_out[l]), hold_h);
          chk("hold_vert", int'(vert_out[l]), hold_v);
        end
      end
      if (wb_valid_out) begin
        if (wb_q.size() == 0) begin
          chk("unexpected_wb", 1, 0);
        end else begin
          me = wb_q.pop_front();
          chk("wb_cycle", cyc, me.c);
          chk("wb_hor", int'(wb_hor_out), me.h);
          chk("wb_vert", int'(wb_vert_out), me.v);
        end
      end
      if (done_q.size() > 0 && cyc == done_q[0] + 1) begin
        done_q.delete(0);
        exp_fc = (exp_fc + 1) % 65536;
      end
      chk("done", int'(done_out), int'(done_q.size() > 0 && done_q[0] == cyc));
      chk("frame_count", int'(frame_count_out), exp_fc);
      chk("busy", int'(busy_out), int'(cyc >= busy_lo && cyc <= busy_hi));
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"}, int'(valid_out), 0);
    chk({tag, "_wb_valid"}, int'(wb_valid_out), 0);
    chk({tag, "_wb_hor"}, int'(wb_hor_out), 0);
    chk({tag, "_wb_vert"}, int'(wb_vert_out), 0);
    chk({tag, "_busy"}, int'(busy_out), 0);
    chk({tag, "_done"}, int'(done_out), 0);
    chk({tag, "_fc"}, int'(frame_count_out), 0);
    chk({tag, "_hor"}, int'(hor_out), 0);
    chk({tag, "_vert"}, int'(vert_out), 0);
  endtask

  // mode 0: random, 1: stall in cycles 3-4, 2: start pulses at 5 and 18, 3: reset in cycle 8.
  // Called at a negedge while the DUT is idle; returns at the negedge of the first idle cycle.
  task automatic run_frame(input int stall_pct, input int spur_pct, input int mode);
    bit pat [512];
    int s, t, done_c;
    s = cyc;
    for (int j = 0; j < 512; j++) begin
      if (mode == 1) pat[j] = (j == 2 || j == 3);
      else if (mode == 0 && j < 400) pat[j] = ($urandom_range(99) < stall_pct);
      else pat[j] = 1'b0;
    end
    t = s;
    for (int k = 0; k < N; k++) begin
      if (k > 0) begin
        t++;
        while (pat[t - s]) t++;
      end
      iss_q.push_back('{k % HP, k / HP, t + 1});
    end
    done_c = t + 1 + D + 1;
    done_q.push_back(done_c);
    busy_lo = s + 1;
    busy_hi = done_c;
    start_in = 1'b1;
    stall_in = 1'b0;
    while (cyc < done_c) begin
      @(negedge clk);
      stall_in = pat[cyc - s];
      if (mode == 2) start_in = (cyc == s + 5 || cyc == s + 18);
      else start_in = ($urandom_range(99) < spur_pct);
      if (mode == 3 && cyc == s + 8) begin
        #2 rst_in = 1'b1;
        #1 reset_checks("midreset");
        iss_q.delete();
        wb_q.delete();
        done_q.delete();
        exp_fc = 0;
        busy_lo = 1;
        busy_hi = 0;
        hold_h = 0;
        hold_v = 0;
        start_in = 1'b0;
        stall_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_in = 1'b0;
        @(negedge clk);
        return;
      end
    end
    @(negedge clk);
    start_in = 1'b0;
    stall_in = 1'b0;
  endtask

  initial begin
    int s2, lh, lv, found, gap;
    rst_in = 1'b1;
    start_in = 1'b0;
    stall_in = 1'b0;
    start2 = 1'b0;
    stall2 = 1'b0;
    repeat (3) @(negedge clk);
    reset_checks("reset");
    rst_in = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(0, 0, 0);
    repeat (3) @(negedge clk);
    run_frame(0, 0, 1);
    repeat (2) @(negedge clk);
    run_frame(0, 0, 2);
    repeat (2) @(negedge clk);
    chk("fc_after_three", int'(frame_count_out), 3);

    run_frame(0, 0, 3);
    chk("fc_after_reset", int'(frame_count_out), 0);
    run_frame(0, 0, 0);
    chk("fc_one_after_reset", int'(frame_count_out), 1);

    for (int f = 0; f < 3; f++) run_frame(20, 10, 0);
    chk("fc_back_to_back", int'(frame_count_out), 4);

    for (int f = 0; f < 5; f++) begin
      run_frame(int'($urandom_range(40)), int'($urandom_range(20)), 0);
      gap = int'($urandom_range(3));
      repeat (gap) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    chk("iss_queue_empty", iss_q.size(), 0);
    chk("wb_queue_empty", wb_q.size(), 0);
    chk("done_queue_empty", done_q.size(), 0);
    chk("fc_final", int'(frame_count_out), 9);

    // Full-size instance: counter wrap and total sweep length.
    force dut2.frame_count_q = 16'hFFFF;
    @(negedge clk);
    release dut2.frame_count_q;
    @(negedge clk);
    s2 = cyc;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    found = 0;
    lh = -1;
    lv = -1;
    for (int k = 0; k < 40000; k++) begin
      if (valid2) begin
        lh = int'(hor2[0]);
        lv = int'(vert2[8]);
      end
      if (done2) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("wrap_done_seen", found, 1);
    chk("wrap_done_cycle", cyc - s2, 31576);
    chk("wrap_last_hor", lh, 204);
    chk("wrap_last_vert", lv, 153);
    chk("wrap_fc_before", int'(fc2), 65535);
    @(negedge clk);
    chk("wrap_fc_after", int'(fc2), 0);
    chk("wrap_busy_after", int'(busy2), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
